// File: rtl/alu_req_arbiter_if.sv
// Bundle of the requester handshakes, the shared ALU port and the response bus.
// The arbiter uses the master view; requesters and ALU see the slave view.
interface alu_req_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
);
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_A;
    logic [WIDTH-1:0]   req0_B;
    logic [FUN_W-1:0]   req0_fun;
    logic               req0_ready;

    logic               req1_valid;
    logic [WIDTH-1:0]   req1_A;
    logic [WIDTH-1:0]   req1_B;
    logic [FUN_W-1:0]   req1_fun;
    logic               req1_ready;

    logic [WIDTH-1:0]   ALU_A;
    logic [WIDTH-1:0]   ALU_B;
    logic [FUN_W-1:0]   ALU_FUN;
    logic               ALU_EN;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               ALU_VALID;

    logic [2*WIDTH-1:0] rsp_data;
    logic               rsp_err;
    logic               rsp0_valid;
    logic               rsp1_valid;

    modport master (
        input  req0_valid, req0_A, req0_B, req0_fun,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_fun,
        output req1_ready,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN,
        input  ALU_OUT, ALU_VALID,
        output rsp_data, rsp_err, rsp0_valid, rsp1_valid
    );

    modport slave (
        output req0_valid, req0_A, req0_B, req0_fun,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_fun,
        input  req1_ready,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN,
        output ALU_OUT, ALU_VALID,
        input  rsp_data, rsp_err, rsp0_valid, rsp1_valid
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters,
// with a watchdog that turns a missing ALU_VALID into an error response.
module alu_req_arbiter #(
    parameter int WIDTH   = 16,
    parameter int FUN_W   = 4,
    parameter int TIMEOUT = 8
) (
    input logic               clk,
    input logic               RST,
    alu_req_arbiter_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state;
    logic               ptr;
    logic               owner;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [FUN_W-1:0]   op_fun;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] rsp_data_q;
    logic               rsp_err_q;
    logic               grant0;
    logic               grant1;
    logic               ops_on;

    // ptr = 1 means req1 is preferred when both requesters are valid
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && RST) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
            grant1 = bus.req1_valid && (!bus.req0_valid || ptr);
        end
    end

    assign ops_on = (state == ISSUE) || (state == WAIT);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.ALU_A      = ops_on ? op_a : '0;
    assign bus.ALU_B      = ops_on ? op_b : '0;
    assign bus.ALU_FUN    = ops_on ? op_fun : '0;
    assign bus.ALU_EN     = (state == ISSUE);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp0_valid = (state == RESP) && !owner;
    assign bus.rsp1_valid = (state == RESP) && owner;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_fun     <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner  <= grant1;
                        ptr    <= grant0;
                        op_a   <= grant1 ? bus.req1_A   : bus.req0_A;
                        op_b   <= grant1 ? bus.req1_B   : bus.req0_B;
                        op_fun <= grant1 ? bus.req1_fun : bus.req0_fun;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // a result on the final watchdog cycle still counts as success
                    if (bus.ALU_VALID) begin
                        rsp_data_q <= bus.ALU_OUT;
                        rsp_err_q  <= 1'b0;
                        state      <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed table, hand-written corner
// sequences and a randomized phase against a transaction-timeline model.
`timescale 1ns/1ps
module tb_alu_req_arbiter;
    localparam int WIDTH   = 16;
    localparam int FUN_W   = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.WIDTH(WIDTH), .FUN_W(FUN_W)) bus ();

    alu_req_arbiter #(.WIDTH(WIDTH), .FUN_W(FUN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int checks;
    int errors;
    int alu_lat;
    int spur_req;
    int spur_ack;
    int alu_cd;
    logic [31:0] alu_res;
    logic [31:0] last_data;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        int          lat;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_cyc;
    } row_t;
    row_t rows[7];

    function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
        case (f)
            4'h0:    return {16'b0, a} + {16'b0, b};
            4'h1:    return {16'b0, a} - {16'b0, b};
            4'h2:    return {16'b0, a} * {16'b0, b};
            default: return {a, b};
        endcase
    endfunction

    // ALU stand-in: result alu_lat cycles after the enable, 0 = never answers
    always @(negedge clk) begin
        bus.ALU_VALID = 1'b0;
        bus.ALU_OUT   = 32'hFFFF_FFFF;
        if (rst_n !== 1'b1) alu_cd = 0;
        if (spur_ack != spur_req) begin
            spur_ack      = spur_req;
            bus.ALU_VALID = 1'b1;
            bus.ALU_OUT   = 32'hBAD0_0BAD;
        end
        if (alu_cd > 0) begin
            alu_cd--;
            if (alu_cd == 0) begin
                bus.ALU_VALID = 1'b1;
                bus.ALU_OUT   = alu_res;
            end
        end
        if (bus.ALU_EN === 1'b1) begin
            alu_cd  = alu_lat;
            alu_res = alu_fn(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] f);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_A = a; bus.req0_B = b; bus.req0_fun = f;
        end else begin
            bus.req1_valid = v; bus.req1_A = a; bus.req1_B = b; bus.req1_fun = f;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.req0_ready, bus.req1_ready, bus.ALU_EN,
                                 bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}), 64'(0));
        chk({tag, "_alu"}, 64'({bus.ALU_A, bus.ALU_B, bus.ALU_FUN}), 64'(0));
        chk({tag, "_data"}, 64'(bus.rsp_data), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_strobe(input string name, output int n);
        n = 0;
        while (n < 30 && bus.rsp0_valid !== 1'b1 && bus.rsp1_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL %s: no response strobe within 30 cycles", name);
        end
    endtask

    task automatic run_row(input row_t r);
        int n;
        @(negedge clk);
        alu_lat = r.lat;
        set_req(r.sel, 1'b1, r.a, r.b, r.f);
        #1;
        chk("row_ready", 64'({bus.req1_ready, bus.req0_ready}), (r.sel == 1) ? 64'(2) : 64'(1));
        @(negedge clk);
        set_req(r.sel, 1'b0, r.a, r.b, r.f);
        chk("row_alu_en", 64'(bus.ALU_EN), 64'(1));
        chk("row_alu_ops", 64'({bus.ALU_A, bus.ALU_B, bus.ALU_FUN}), 64'({r.a, r.b, r.f}));
        wait_strobe("row_strobe_wait", n);
        chk("row_latency", 64'(n + 1), 64'(r.exp_cyc));
        chk("row_strobe", 64'({bus.rsp1_valid, bus.rsp0_valid}), (r.sel == 1) ? 64'(2) : 64'(1));
        chk("row_rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'({r.exp_err, r.exp_data}));
        last_data = r.exp_data;
        @(negedge clk);
        chk("row_back_idle", 64'({bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN,
                                  bus.rsp0_valid, bus.rsp1_valid}), 64'(0));
    endtask

    task automatic contention();
        int w, n, c0, c1;
        logic [31:0] expd;
        pulse_reset();
        alu_lat = 1;
        c0 = 0;
        c1 = 0;
        set_req(0, 1'b1, 16'h0100, 16'h0001, 4'h0);
        set_req(1, 1'b1, 16'h0200, 16'h0002, 4'h0);
        for (int i = 0; i < 5; i++) begin
            n = 0;
            #1;
            while (n < 20 && bus.req0_ready !== 1'b1 && bus.req1_ready !== 1'b1) begin
                @(negedge clk);
                #1;
                n++;
            end
            w = (bus.req1_ready === 1'b1) ? 1 : 0;
            chk("rr_grant_order", 64'(w), 64'(i % 2));
            expd = (w == 1) ? 32'h0202 + 32'(c1) : 32'h0101 + 32'(c0);
            @(negedge clk);
            if (w == 0) begin
                c0++;
                set_req(0, i < 3, 16'h0100 + 16'(c0), 16'h0001, 4'h0);
            end else begin
                c1++;
                set_req(1, i < 3, 16'h0200 + 16'(c1), 16'h0002, 4'h0);
            end
            wait_strobe("rr_strobe_wait", n);
            chk("rr_rsp_owner", 64'({bus.rsp1_valid, bus.rsp0_valid}), (w == 1) ? 64'(2) : 64'(1));
            chk("rr_rsp_data", 64'({bus.rsp_err, bus.rsp_data}), 64'({1'b0, expd}));
            last_data = expd;
        end
    endtask

    task automatic spurious();
        int n;
        @(negedge clk);
        spur_req++;
        repeat (3) begin
            @(negedge clk);
            chk("spur_no_strobe", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(0));
            chk("spur_data_held", 64'({bus.rsp_err, bus.rsp_data}), 64'({1'b0, last_data}));
        end
        @(negedge clk);
        alu_lat = 3;
        set_req(0, 1'b1, 16'h0030, 16'h0004, 4'h2);
        #1;
        chk("spur_cmd_ready", 64'(bus.req0_ready), 64'(1));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        n = 0;
        while (n < 30 && bus.rsp0_valid !== 1'b1) begin
            chk("spur_data_until_result", 64'(bus.rsp_data), 64'(last_data));
            @(negedge clk);
            n++;
        end
        chk("spur_result", 64'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_data}),
            64'({2'b01, 1'b0, 32'h0000_00C0}));
    endtask

    task automatic busy_hold();
        int n;
        @(negedge clk);
        alu_lat = 4;
        set_req(0, 1'b1, 16'h0009, 16'h0002, 4'h1);
        #1;
        chk("busy_grant0", 64'(bus.req0_ready), 64'(1));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        set_req(1, 1'b1, 16'h0040, 16'h0040, 4'h2);
        n = 0;
        while (n < 30 && bus.rsp0_valid !== 1'b1) begin
            #1;
            chk("busy_ready1_low", 64'(bus.req1_ready), 64'(0));
            @(negedge clk);
            n++;
        end
        #1;
        chk("busy_ready1_low_resp", 64'(bus.req1_ready), 64'(0));
        chk("busy_rsp0", 64'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_data}),
            64'({2'b01, 1'b0, 32'h0000_0007}));
        @(negedge clk);
        alu_lat = 1;
        #1;
        chk("busy_ready1_idle", 64'(bus.req1_ready), 64'(1));
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_strobe("busy_rsp1_wait", n);
        chk("busy_rsp1", 64'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_data}),
            64'({2'b10, 1'b0, 32'h0000_1000}));
    endtask

    task automatic mid_reset();
        int n;
        @(negedge clk);
        alu_lat = 0;
        set_req(0, 1'b1, 16'h1111, 16'h2222, 4'h0);
        #1;
        chk("midreset_grant0", 64'(bus.req0_ready), 64'(1));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_in_wait", 64'({bus.ALU_EN, bus.ALU_A}), 64'({1'b0, 16'h1111}));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        alu_lat = 1;
        set_req(1, 1'b1, 16'h0003, 16'h0004, 4'h2);
        #1;
        chk("midreset_req1_grant", 64'({bus.req1_ready, bus.req0_ready}), 64'(2));
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_strobe("midreset_rsp_wait", n);
        chk("midreset_rsp1", 64'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_data}),
            64'({2'b10, 1'b0, 32'h0000_000C}));
    endtask

    // Timeline model: a grant at cycle g issues at g+1 and answers at g+2+latency,
    // or at g+2+TIMEOUT with an error when the ALU is silent for too long.
    task automatic random_phase(input int ncyc);
        bit          act, idle, pend[2];
        int          g_cyc, r_cyc, own, ptr, w, lat;
        logic [15:0] ra[2], rb[2], opa, opb;
        logic [3:0]  rf[2], opf;
        logic [31:0] exp_data, pend_data;
        logic        exp_err, pend_err;
        pulse_reset();
        act = 0; ptr = 0; own = 0; g_cyc = 0; r_cyc = 0;
        exp_data = '0; exp_err = 1'b0; pend_data = '0; pend_err = 1'b0;
        opa = '0; opb = '0; opf = '0;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 0; ra[n] = '0; rb[n] = '0; rf[n] = '0;
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            idle = !act || cyc > r_cyc;
            if (act && cyc == r_cyc) begin
                exp_data = pend_data;
                exp_err  = pend_err;
            end
            chk("rnd_alu_en", 64'(bus.ALU_EN), 64'(act && cyc == g_cyc + 1));
            if (!(act && cyc == r_cyc))
                chk("rnd_alu_ops", 64'({bus.ALU_A, bus.ALU_B, bus.ALU_FUN}),
                    (act && cyc > g_cyc && cyc < r_cyc) ? 64'({opa, opb, opf}) : 64'(0));
            chk("rnd_strobe", 64'({bus.rsp1_valid, bus.rsp0_valid}),
                (act && cyc == r_cyc) ? ((own == 1) ? 64'(2) : 64'(1)) : 64'(0));
            chk("rnd_rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'({exp_err, exp_data}));

            if (idle) begin
                case ($urandom_range(0, 9))
                    0:       alu_lat = 0;
                    1:       alu_lat = TIMEOUT;
                    2:       alu_lat = TIMEOUT + 1;
                    3:       alu_lat = TIMEOUT - 1;
                    default: alu_lat = int'($urandom_range(1, 3));
                endcase
                if ($urandom_range(0, 9) == 0) spur_req++;
            end
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 2) == 0) begin
                    pend[n] = 1;
                    ra[n] = 16'($urandom);
                    rb[n] = 16'($urandom);
                    rf[n] = 4'($urandom_range(0, 15));
                end
                set_req(n, pend[n], ra[n], rb[n], rf[n]);
            end
            #1;
            w = -1;
            if (idle) begin
                if (pend[0] && (!pend[1] || ptr == 0)) w = 0;
                else if (pend[1]) w = 1;
            end
            chk("rnd_ready", 64'({bus.req1_ready, bus.req0_ready}),
                (w == 1) ? 64'(2) : (w == 0) ? 64'(1) : 64'(0));
            if (w >= 0) begin
                act = 1; g_cyc = cyc; own = w; ptr = 1 - w;
                opa = ra[w]; opb = rb[w]; opf = rf[w];
                lat = alu_lat;
                if (lat >= 1 && lat <= TIMEOUT) begin
                    r_cyc = cyc + 2 + lat; pend_data = alu_fn(opa, opb, opf); pend_err = 1'b0;
                end else begin
                    r_cyc = cyc + 2 + TIMEOUT; pend_data = '0; pend_err = 1'b1;
                end
                pend[w] = 0;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        rows[0] = '{0, 16'h0005, 16'h0003, 4'h0, 1,           32'h0000_0008, 1'b0, 3};
        rows[1] = '{1, 16'hFFFF, 16'h0001, 4'h0, 3,           32'h0001_0000, 1'b0, 5};
        rows[2] = '{0, 16'h1234, 16'h0100, 4'h2, 2,           32'h0012_3400, 1'b0, 4};
        rows[3] = '{1, 16'hDEAD, 16'hBEEF, 4'h7, TIMEOUT + 1, 32'h0000_0000, 1'b1, 10};
        rows[4] = '{0, 16'h0007, 16'h0009, 4'h1, TIMEOUT,     32'hFFFF_FFFE, 1'b0, 10};
        rows[5] = '{1, 16'h0002, 16'h0003, 4'h2, 0,           32'h0000_0000, 1'b1, 10};
        rows[6] = '{1, 16'h00FF, 16'h00FF, 4'h2, 1,           32'h0000_FE01, 1'b0, 3};

        checks = 0;
        errors = 0;
        spur_req = 0;
        alu_lat = 1;
        last_data = '0;
        rst_n = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_values");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_row(rows[i]);
        contention();
        spurious();
        busy_hold();
        mid_reset();
        random_phase(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
